// File: rtl/twowire_host_serdes_pkg.sv
// twowire_host_pkg: shared FSM encoding, bit-count widths and length clamp for the Two-Wire host serdes.
package twowire_host_pkg;
   typedef enum logic [2:0] {IDLE, TX, TURN, RX, DONE} state_t;
   localparam int unsigned MAX_BITS = 32;
   localparam int BIT_W = $clog2(MAX_BITS + 1);
   localparam int IDX_W = $clog2(MAX_BITS);
   function automatic logic [BIT_W-1:0] clamp_len(input int unsigned len);
      return (len > MAX_BITS) ? BIT_W'(MAX_BITS) : BIT_W'(len);
   endfunction
endpackage

// File: rtl/twowire_host_serdes_if.sv
// twowire_host_serdes_if: request/response handshake between the host sequencer (master) and the serdes (slave).
interface twowire_host_serdes_if #(
   parameter int LEN_W = 6
) ();
   logic             req_valid;
   logic             req_ready;
   logic [LEN_W-1:0] req_tx_len;
   logic [31:0]      req_tx_data;
   logic [LEN_W-1:0] req_rx_len;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   modport master (output req_valid, req_tx_len, req_tx_data, req_rx_len, rsp_ready,
                   input  req_ready, rsp_valid, rsp_data);
   modport slave  (input  req_valid, req_tx_len, req_tx_data, req_rx_len, rsp_ready,
                   output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/twowire_host_serdes_clkgen.sv
// twowire_host_clkgen: divides clk into DCK bit periods (low phase then high phase) with phase strobes.
module twowire_host_clkgen #(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic drst_n,
   input  logic run,
   output logic dck,
   output logic fall_stb,
   output logic rise_stb,
   output logic last_hi_stb
);
   localparam int CW = $clog2(2 * CLKDIV);
   localparam logic [CW-1:0] LAST = CW'(2 * CLKDIV - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, dck_q;
   assign cnt_d       = (!run || !run_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   assign dck         = dck_q;
   assign fall_stb    = run_q && cnt_q == '0;
   assign rise_stb    = run_q && cnt_q == CW'(CLKDIV);
   assign last_hi_stb = run_q && cnt_q == LAST;
   // Period counter restarts at the first low-phase clk; dck is registered from the next count.
   always_ff @(posedge clk or negedge drst_n)
      if (!drst_n) begin
         cnt_q <= '0;
         run_q <= 1'b0;
         dck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run;
         dck_q <= cnt_d >= CW'(CLKDIV);
      end
endmodule

// File: rtl/twowire_host_serdes.sv
// twowire_host_serdes: host-side Two-Wire Debug serdes; shifts TX bits out on DIO, turns the bus, shifts RX bits in.
// Build option TWOWIRE_HOST_INPUT_SYNC_EN: DIO input passes a 2-flop synchronizer and capture moves 2 clk later.
module twowire_host_serdes
   import twowire_host_pkg::*;
#(
   parameter int CLKDIV      = 4,
   parameter int TURN_CYCLES = 1,
   parameter int LEN_W       = 6
) (
   input  logic                 clk,
   input  logic                 drst_n,
   input  logic                 abort,
   twowire_host_serdes_if.slave bus,
   output logic                 dck,
   output logic                 dio_o,
   output logic                 dio_oe,
   input  logic                 dio_i
);
   state_t             state_q, state_d;
   logic [BIT_W-1:0]   bit_q, bit_d, tx_len_q, tx_len_d, rx_len_q, rx_len_d, cnt_nxt;
   logic [31:0]        tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
   logic               dio_o_q, dio_o_d, dio_oe_q, dio_oe_d;
   logic               req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
   logic [LEN_W-1:0]   tx_len_in, rx_len_in;
   logic               run, last_hi, fall_stb, rise_stb, unused_stb;
   logic               din, cap_stb, rx_last;
   logic [IDX_W-1:0]   rx_idx;
   assign tx_len_in     = bus.req_tx_len;
   assign rx_len_in     = bus.req_rx_len;
   assign cnt_nxt       = bit_q + 1'b1;
   assign run           = state_d inside {TX, TURN, RX};
   assign unused_stb    = fall_stb ^ rise_stb;
   assign dio_o         = dio_o_q;
   assign dio_oe        = dio_oe_q;
   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   twowire_host_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
      .clk        (clk),
      .drst_n     (drst_n),
      .run        (run),
      .dck        (dck),
      .fall_stb   (fall_stb),
      .rise_stb   (rise_stb),
      .last_hi_stb(last_hi)
   );
`ifdef TWOWIRE_HOST_INPUT_SYNC_EN
   logic [1:0] sync_q, cap_q;
   assign din     = sync_q[1];
   assign cap_stb = cap_q[1];
   assign rx_idx  = IDX_W'(bit_q - 1'b1);
   assign rx_last = bit_q == rx_len_q;
   // Synchronize DIO and delay the capture strobe to line up with the synchronized sample.
   always_ff @(posedge clk or negedge drst_n)
      if (!drst_n) begin
         sync_q <= '0;
         cap_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], dio_i};
         cap_q  <= {cap_q[0], state_q == RX && last_hi};
      end
`else
   assign din     = dio_i;
   assign cap_stb = last_hi;
   assign rx_idx  = bit_q[IDX_W-1:0];
   assign rx_last = cnt_nxt == rx_len_q;
`endif
   // Next-state logic: accept, per-period bit sequencing, capture, abort and response hold.
   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      tx_len_d = tx_len_q;
      rx_len_d = rx_len_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      dio_o_d  = dio_o_q;
      dio_oe_d = dio_oe_q;
      case (state_q)
         IDLE: if (bus.req_valid && req_ready_q) begin
            tx_len_d = clamp_len(32'(tx_len_in));
            rx_len_d = clamp_len(32'(rx_len_in));
            tx_d     = bus.req_tx_data >> 1;
            rx_d     = '0;
            bit_d    = '0;
            dio_oe_d = tx_len_d != '0;
            dio_o_d  = (tx_len_d != '0) && bus.req_tx_data[0];
            state_d  = (tx_len_d != '0) ? TX : (rx_len_d != '0) ? TURN : DONE;
         end
         TX: if (last_hi) begin
            bit_d   = cnt_nxt;
            dio_o_d = tx_q[0];
            tx_d    = tx_q >> 1;
            if (cnt_nxt == tx_len_q) begin
               bit_d    = '0;
               dio_o_d  = 1'b0;
               dio_oe_d = 1'b0;
               state_d  = (rx_len_q != '0) ? TURN : DONE;
            end
         end
         TURN: if (last_hi) begin
            bit_d = cnt_nxt;
            if (cnt_nxt == BIT_W'(TURN_CYCLES)) begin
               bit_d   = '0;
               state_d = RX;
            end
         end
         RX: begin
            if (last_hi) bit_d = cnt_nxt;
            if (cap_stb) begin
               rx_d[rx_idx] = din;
               if (rx_last) state_d = DONE;
            end
         end
         DONE: if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && state_q inside {TX, TURN, RX}) begin
         state_d  = IDLE;
         bit_d    = '0;
         dio_o_d  = 1'b0;
         dio_oe_d = 1'b0;
      end
      rsp_data_d  = (state_d == DONE && state_q != DONE) ? rx_d : rsp_data_q;
      rsp_valid_d = state_d == DONE;
      req_ready_d = state_d == IDLE;
   end
   // FSM and registered pin/handshake outputs; reset aborts everything with no response.
   always_ff @(posedge clk or negedge drst_n)
      if (!drst_n) begin
         state_q     <= IDLE;
         bit_q       <= '0;
         tx_len_q    <= '0;
         rx_len_q    <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         rsp_data_q  <= '0;
         dio_o_q     <= 1'b0;
         dio_oe_q    <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         tx_len_q    <= tx_len_d;
         rx_len_q    <= rx_len_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         rsp_data_q  <= rsp_data_d;
         dio_o_q     <= dio_o_d;
         dio_oe_q    <= dio_oe_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
endmodule

// File: tb/tb_twowire_host_serdes.sv
// tb_twowire_host_serdes: directed + randomized bench with a behavioural DIO target and transaction model.
module tb_twowire_host_serdes;
   localparam int CLKDIV = 4;
   localparam int TURN   = 1;
`ifdef TWOWIRE_HOST_INPUT_SYNC_EN
   localparam int SYNC_EXTRA = 2;
`else
   localparam int SYNC_EXTRA = 0;
`endif
   logic clk = 1'b0, drst_n = 1'b0, abort = 1'b0, dio_i = 1'b0;
   logic dck, dio_o, dio_oe;
   int checks = 0, passes = 0, rise_cnt = 0, m_tx = 0, m_rx = 0;
   logic [31:0] m_data = '0, m_word = '0, saved;
   twowire_host_serdes_if #(.LEN_W(6)) bus ();
   twowire_host_serdes #(.CLKDIV(CLKDIV), .TURN_CYCLES(TURN), .LEN_W(6)) dut (
      .clk(clk), .drst_n(drst_n), .abort(abort), .bus(bus),
      .dck(dck), .dio_o(dio_o), .dio_oe(dio_oe), .dio_i(dio_i));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int clamp(input int n);
      return n > 32 ? 32 : n;
   endfunction

   function automatic int periods(input int tx, input int rx);
      return tx + (rx > 0 ? TURN + rx : 0);
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] w, input int n);
      logic [63:0] m;
      m = (64'd1 << n) - 64'd1;
      return w & m[31:0];
   endfunction

   // Target + pin monitor: on every DCK rise, check the driven TX bit (or release) and present the RX bit.
   initial forever begin
      int p;
      @(posedge dck);
      #1;
      p = rise_cnt;
      if (p < m_tx) chk("tx_bit", {dio_oe, dio_o}, {1'b1, m_data[p]});
      else chk("released", dio_oe, 1'b0);
      dio_i = (p >= m_tx + TURN && p < m_tx + TURN + m_rx) ? m_word[p - m_tx - TURN] : 1'($urandom_range(0, 1));
      rise_cnt++;
   end

   task automatic set_req(input int tx, input logic [31:0] d, input int rx, input logic [31:0] w);
      m_tx = clamp(tx); m_rx = clamp(rx); m_data = d; m_word = w; rise_cnt = 0;
      bus.req_tx_len = 6'(tx); bus.req_rx_len = 6'(rx); bus.req_tx_data = d; bus.req_valid = 1'b1;
   endtask

   task automatic start_txn(input int tx, input logic [31:0] d, input int rx, input logic [31:0] w);
      int n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) chk("ready_timeout", bus.req_ready, 1);
      set_req(tx, d, rx, w);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      chk("ready_low_after_accept", bus.req_ready, 0);
   endtask

   task automatic wait_rsp();
      int lat = 0;
      do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 3000);
      chk("latency", lat, 2 * CLKDIV * periods(m_tx, m_rx) + 1 + (m_rx > 0 ? SYNC_EXTRA : 0));
      chk("rsp_data", bus.rsp_data, exp_word(m_word, m_rx));
      chk("dck_rises", rise_cnt, periods(m_tx, m_rx));
      chk("done_pins", {dck, dio_oe, dio_o}, 0);
   endtask

   task automatic ack();
      @(negedge clk) bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; bus.req_tx_len = '0; bus.req_rx_len = '0; bus.req_tx_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_pins", {dck, dio_o, dio_oe}, 0);
      chk("rst_handshake", {bus.req_ready, bus.rsp_valid}, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      drst_n = 1'b1;
      chk("ready_still_low", bus.req_ready, 0);
      @(negedge clk);
      chk("ready_after_release", bus.req_ready, 1);
      start_txn(8, 32'hA5, 0, 32'h0);
      wait_rsp();
      ack();
      start_txn(4, 32'h9, 8, 32'h3C);
      wait_rsp();
      ack();
      start_txn(0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
      wait_rsp();
      ack();
      start_txn(3, 32'h5, 5, 32'h1F3);
      wait_rsp();
      saved = bus.rsp_data;
      @(negedge clk);
      set_req(2, 32'h2, 2, 32'h3);
      for (int i = 0; i < 20; i++) begin
         abort = (i == 5);
         @(negedge clk);
         chk("hold_rsp_valid", bus.rsp_valid, 1);
         chk("hold_req_ready", bus.req_ready, 0);
         chk("hold_rsp_data", bus.rsp_data, saved);
      end
      abort = 1'b0;
      chk("hold_no_dck", rise_cnt, 0);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("ready_after_ack", {bus.req_ready, bus.rsp_valid}, 2'b10);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      chk("pending_accepted", bus.req_ready, 0);
      wait_rsp();
      ack();
      start_txn(40, 32'hDEAD_BEEF, 33, 32'hCAFE_F00D);
      wait_rsp();
      ack();
      for (int i = 0; i < 12; i++) begin
         start_txn($urandom_range(0, 40), $urandom, $urandom_range(0, 40), $urandom);
         wait_rsp();
         repeat ($urandom_range(0, 3)) @(negedge clk);
         ack();
      end
      saved = bus.rsp_data;
      start_txn(2, 32'h1, 8, 32'hA7);
      begin
         int n = 0;
         while (rise_cnt < 2 + TURN + 4 && n < 2000) begin @(negedge clk); n++; end
         if (n >= 2000) chk("abort_wait_timeout", rise_cnt, 2 + TURN + 4);
      end
      @(negedge clk) abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      chk("abort_pins", {dck, dio_oe, dio_o}, 0);
      chk("abort_idle", bus.req_ready, 1);
      begin
         int seen = 0;
         repeat (100) begin @(negedge clk); if (bus.rsp_valid) seen++; end
         chk("abort_no_rsp", seen, 0);
      end
      chk("abort_rsp_data_kept", bus.rsp_data, saved);
      start_txn(16, 32'h0000_F0F0, 4, 32'hF);
      begin
         int n = 0;
         while (rise_cnt < 3 && n < 2000) begin @(negedge clk); n++; end
      end
      #2 drst_n = 1'b0;
      #1;
      chk("async_rst_pins", {dck, dio_oe, dio_o}, 0);
      chk("async_rst_handshake", {bus.req_ready, bus.rsp_valid}, 0);
      chk("async_rst_data", bus.rsp_data, 0);
      repeat (2) @(negedge clk);
      drst_n = 1'b1;
      start_txn(5, 32'h15, 6, 32'h2B);
      wait_rsp();
      ack();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/twowire_host_serdes.md
Name: twowire_host_serdes

Overview:
- Host-side (probe) serializer/deserializer for the Two-Wire Debug link; the opposite end to the DTM's registered DIO pin.
- Generates DCK from the system clock.
- Shifts a request's command/data bits out on DIO, releases DIO for turnaround, then shifts target response bits in.
- Sits between the host's transaction sequencer (valid/ready request and response) and the DCK/DIO pads.

Parameters:
- CLKDIV, 4: clk cycles per DCK phase (low or high); legal >= 2, or >= 3 with sync option.
- TURN_CYCLES, 1: DCK periods with DIO undriven between TX and RX phases; legal 1..3.
- LEN_W, 6: width of the length fields; lengths are clamped to 32.

Ports:
- clk  in  1  system clock; all logic is posedge.
- drst_n  in  1  reset, asynchronous, active-low.
- abort  in  1  cancel the in-flight transaction.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_tx_len  in  LEN_W  bits to send, 0..32.
- req_tx_data  in  32  TX bits, LSB first.
- req_rx_len  in  LEN_W  bits to receive, 0..32.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_data  out  32  RX bits, LSB first; bits at and above rx_len are zero.
- dck  out  1  debug clock pin.
- dio_o  out  1  DIO output value.
- dio_oe  out  1  DIO output enable.
- dio_i  in  1  DIO pad input.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, dck=0, dio_o=0, dio_oe=0, all state IDLE. Reset is asynchronous and aborts mid-operation with no response. req_ready rises one clk after reset is released.
- FSM states: IDLE, TX, TURN, RX, DONE.
- Bit period: 2*CLKDIV clk cycles.
  - Low phase first (dck=0), then high phase (dck=1).
  - All pin changes are registered and occur at the start of the low phase, coincident with DCK falling.
- IDLE:
  - dck=0, dio_oe=0.
  - req_ready=1 when rsp_valid=0.
  - On accept at cycle T, latch the lengths (clamped to 32) and the data.
  - Next state: TX if tx_len>0; else TURN if rx_len>0; else DONE.
- TX:
  - Bit i is driven from T+1+2*CLKDIV*i with dio_oe=1 and dio_o=tx_data[i].
  - After tx_len periods: go to TURN if rx_len>0, else DONE.
- TURN:
  - dio_oe=0 and dio_o=0 from the start of the phase.
  - DCK keeps toggling for TURN_CYCLES periods, then go to RX.
- RX:
  - dio_oe=0.
  - Bit k is captured from dio_i on the final clk of its high phase (the cycle before DCK falls) into rsp_data[k].
  - After rx_len periods go to DONE.
- DONE:
  - dck=0, dio_oe=0.
  - rsp_valid=1 and rsp_data is held stable until rsp_valid && rsp_ready, then go to IDLE.
  - req_ready stays 0 while rsp_valid=1.
- Latency, accept to rsp_valid: 2*CLKDIV*(tx_len + (rx_len>0 ? TURN_CYCLES+rx_len : 0)) + 1 clk.
- Length 0 for both fields: rsp_valid at T+1 with rsp_data=0; dck never toggles.
- abort:
  - In TX/TURN/RX: at the next clk go to IDLE with dck=0, dio_oe=0, no response, rsp_data unchanged.
  - Ignored in IDLE and DONE.
  - abort in the same cycle as accept: the request is still accepted, then aborted the next cycle.
- Bit and period counters are sized to exactly cover 32 bits and CLKDIV with no wrap.
- Lengths above 32 are clamped before use.

Optional Feature:
- Macro: TWOWIRE_HOST_INPUT_SYNC_EN.
- Defined:
  - dio_i passes through a 2-flop synchronizer before use.
  - The RX capture point moves 2 clk later (into the following low phase).
  - The last RX bit's low phase is extended by 2 clk before DONE, which adds 2 clk to latency when rx_len>0.
  - CLKDIV must be >= 3.
- Undefined: single capture flop at the point defined above; no added latency.

Decomposition:
- Package twowire_host_pkg holds:
  - FSM state encoding.
  - MAX_BITS=32 and the counter widths derived from it and LEN_W.
- Sub-module twowire_host_clkgen:
  - Inputs: run, CLKDIV.
  - Outputs: dck, fall_stb (start of low phase), rise_stb, last_hi_stb (final clk of high phase).
  - run deassertion forces dck=0 and clears the divider.

Test Plan:
- CLKDIV=4, tx_len=8, tx_data=0xA5, rx_len=0:
  - dio_o sequence 1,0,1,0,0,1,0,1, each held for 8 clk with dio_oe=1.
  - 8 DCK rising edges.
  - rsp_valid at T+65 with rsp_data=0.
- tx_len=4, rx_len=8; target model drives 0x3C after turnaround:
  - dio_oe falls after 4 bits.
  - 1 DCK turnaround period.
  - rsp_data=0x0000003C at T+8*(4+1+8)+1=T+105.
- tx_len=0, rx_len=0: rsp_valid at T+1, dck constant 0.
- rsp_ready held low for 20 clk after rsp_valid:
  - rsp_data stable, req_ready=0, a new req_valid is not accepted.
  - The request is accepted in the cycle after the rsp handshake.
- abort pulsed mid-RX (bit 3 of 8): next clk dck=0, dio_oe=0, state IDLE, rsp_valid never asserts.
- drst_n asserted mid-TX: all outputs 0 asynchronously; after release a fresh request completes normally.
